// File: rtl/fifo_param_pkg.sv
// Shared defaults, depth helper and operation encoding for the fifo_param family.
package fifo_param_pkg;

   localparam int FIFO_DEF_DATA_W = 8;
   localparam int FIFO_DEF_ADDR_W = 3;

   // Encoding is {write accepted, read accepted}
   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_RD    = 2'b01,
      OP_WR    = 2'b10,
      OP_WR_RD = 2'b11
   } fifo_op_e;

   function automatic int fifo_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer bus of fifo_param: write/read requests, data and status flags.
interface fifo_param_if
   import fifo_param_pkg::*;
#(
   parameter int DATA_W = FIFO_DEF_DATA_W,
   parameter int ADDR_W = FIFO_DEF_ADDR_W
);

   logic [DATA_W-1:0] buf_in;
   logic              wr_en;
   logic              rd_en;
   logic              err_clr;
   logic [DATA_W-1:0] buf_out;
   logic              buf_empty;
   logic              buf_full;
   logic              almost_empty;
   logic              almost_full;
   logic [ADDR_W:0]   fifo_counter;
   logic              overflow;
   logic              underflow;

   modport master (
      output buf_in, wr_en, rd_en, err_clr,
      input  buf_out, buf_empty, buf_full, almost_empty, almost_full,
             fifo_counter, overflow, underflow
   );

   modport slave (
      input  buf_in, wr_en, rd_en, err_clr,
      output buf_out, buf_empty, buf_full, almost_empty, almost_full,
             fifo_counter, overflow, underflow
   );

endinterface

// File: rtl/fifo_param_mem.sv
// FIFO storage: DEPTH x DATA_W register array, one synchronous write port, one asynchronous read port.
module fifo_param_mem
   import fifo_param_pkg::*;
#(
   parameter int DATA_W = FIFO_DEF_DATA_W,
   parameter int ADDR_W = FIFO_DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = fifo_depth(ADDR_W);

   // Contents are deliberately left unreset; occupancy tracking makes stale words invisible
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with almost-full/empty thresholds, sticky error flags
// and a selectable registered or first-word-fall-through read port.
module fifo_param
   import fifo_param_pkg::*;
#(
   parameter int DATA_W    = FIFO_DEF_DATA_W,
   parameter int ADDR_W    = FIFO_DEF_ADDR_W,
   parameter int AF_THRESH = 6,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input logic         clk,
   input logic         rst,
   fifo_param_if.slave bus
);

   localparam int                DEPTH     = fifo_depth(ADDR_W);
   localparam int                CNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_AF    = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0]  CNT_AE    = CNT_W'(AE_THRESH);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic              empty;
   logic              full;
   logic              rd_ok;
   logic              wr_ok;
   logic [DATA_W-1:0] rd_data;
   fifo_op_e          op;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_DEPTH);
   // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write
   assign rd_ok = bus.rd_en & ~empty;
   assign wr_ok = bus.wr_en & (~full | rd_ok);
   assign op    = fifo_op_e'({wr_ok, rd_ok});

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      case (op)
         OP_WR: begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
         end
         OP_RD: begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
         end
         OP_WR_RD: begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         default: begin
         end
      endcase
   end

   // Set events take priority over a clear in the same cycle
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (bus.wr_en & ~wr_ok) begin
         overflow_d = 1'b1;
      end
      if (bus.rd_en & ~rd_ok) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_param_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_ok),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.buf_in),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is shown directly; forced to zero while nothing valid is stored
         assign bus.buf_out = empty ? '0 : rd_data;
      end else begin : g_reg
         logic [DATA_W-1:0] buf_out_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               buf_out_q <= '0;
            end else if (rd_ok) begin
               buf_out_q <= rd_data;
            end
         end
         assign bus.buf_out = buf_out_q;
      end
   endgenerate

   assign bus.buf_empty    = empty;
   assign bus.buf_full     = full;
   assign bus.almost_empty = (count_q <= CNT_AE);
   assign bus.almost_full  = (count_q >= CNT_AF);
   assign bus.fifo_counter = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: one registered-read and one fall-through instance.
module tb_fifo_param;

   localparam int DW = 8;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) a_if ();
   fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) f_if ();

   fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut_f (
      .clk (clk),
      .rst (rst),
      .bus (f_if.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [DW-1:0] exp_a[$];
   logic [DW-1:0] exp_f[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic stat_a(input string tag, input int cnt, input bit e, input bit f,
                         input bit ae, input bit af, input bit ov, input bit un);
      check({tag, "_count"}, a_if.fifo_counter, cnt);
      check({tag, "_empty"}, a_if.buf_empty, e);
      check({tag, "_full"}, a_if.buf_full, f);
      check({tag, "_aempty"}, a_if.almost_empty, ae);
      check({tag, "_afull"}, a_if.almost_full, af);
      check({tag, "_ovf"}, a_if.overflow, ov);
      check({tag, "_udf"}, a_if.underflow, un);
   endtask

   // Inputs change on the falling edge and are held for one full rising edge
   task automatic cyc_a(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
      a_if.wr_en = wr; a_if.buf_in = d; a_if.rd_en = rd; a_if.err_clr = clr;
      @(posedge clk);
      @(negedge clk);
      a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.err_clr = 1'b0;
   endtask

   task automatic cyc_f(input bit wr, input logic [DW-1:0] d, input bit rd);
      f_if.wr_en = wr; f_if.buf_in = d; f_if.rd_en = rd;
      @(posedge clk);
      @(negedge clk);
      f_if.wr_en = 1'b0; f_if.rd_en = 1'b0;
   endtask

   task automatic push_a(input logic [DW-1:0] d); cyc_a(1'b1, d, 1'b0, 1'b0); endtask
   task automatic idle_a();                       cyc_a(1'b0, '0, 1'b0, 1'b0); endtask
   task automatic pop_a(input logic [DW-1:0] e);
      exp_a.push_back(e);
      cyc_a(1'b0, '0, 1'b1, 1'b0);
   endtask
   task automatic pop_f(input logic [DW-1:0] e);
      exp_f.push_back(e);
      cyc_f(1'b0, '0, 1'b1);
   endtask

   // Registered-read monitor: an accepted read shows its word one cycle later
   initial begin : mon_a
      bit pend;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            if (exp_a.size() == 0) begin
               n_checks++;
               $display("FAIL sb_a_data: got %0d, expected no read", a_if.buf_out);
            end else begin
               check("sb_a_data", a_if.buf_out, exp_a.pop_front());
            end
         end
         #2;
         pend = !rst && a_if.rd_en && !a_if.buf_empty;
      end
   end

   // Fall-through monitor: the word on buf_out during an accepted read is the one consumed
   initial begin : mon_f
      forever begin
         @(negedge clk);
         #2;
         if (!rst && f_if.rd_en && !f_if.buf_empty) begin
            if (exp_f.size() == 0) begin
               n_checks++;
               $display("FAIL sb_f_data: got %0d, expected no read", f_if.buf_out);
            end else begin
               check("sb_f_data", f_if.buf_out, exp_f.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      a_if.buf_in = '0; a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.err_clr = 1'b0;
      f_if.buf_in = '0; f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.err_clr = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      stat_a("reset", 0, 1, 0, 1, 0, 0, 0);
      check("reset_bufout", a_if.buf_out, 0);
      rst = 1'b0;

      // Reset mid-stream with five words stored
      for (int i = 1; i <= 6; i++) push_a(8'(i));
      pop_a(8'd1);
      idle_a();
      check("pre_rst_count", a_if.fifo_counter, 5);
      check("pre_rst_bufout", a_if.buf_out, 1);
      rst = 1'b1;
      #1;
      stat_a("midrst", 0, 1, 0, 1, 0, 0, 0);
      check("midrst_bufout", a_if.buf_out, 0);
      @(negedge clk);
      rst = 1'b0;
      push_a(8'd7);
      pop_a(8'd7);
      idle_a();
      check("post_rst_count", a_if.fifo_counter, 0);

      // Fill to full, then one rejected push
      for (int i = 1; i <= 9; i++) begin
         push_a(8'(i * 10));
         if (i == 2) check("fill2_aempty", a_if.almost_empty, 1);
         if (i == 3) check("fill3_aempty", a_if.almost_empty, 0);
         if (i == 5) check("fill5_afull", a_if.almost_full, 0);
         if (i == 6) check("fill6_afull", a_if.almost_full, 1);
         if (i == 7) check("fill7_full", a_if.buf_full, 0);
         if (i == 8) check("fill8_ovf", a_if.overflow, 0);
      end
      stat_a("overflow", 8, 0, 1, 0, 1, 1, 0);
      for (int i = 1; i <= 8; i++) pop_a(8'(i * 10));
      idle_a();
      stat_a("drained", 0, 1, 0, 1, 0, 1, 0);
      cyc_a(1'b0, '0, 1'b0, 1'b1);
      check("ovf_clr", a_if.overflow, 0);

      // Push/pop pairs wrapping both pointers twice
      for (int i = 0; i < 16; i++) begin
         push_a(8'(i * 7 + 3));
         pop_a(8'(i * 7 + 3));
      end
      idle_a();
      check("wrap_count", a_if.fifo_counter, 0);
      check("wrap_empty", a_if.buf_empty, 1);

      // Simultaneous write and read while full
      for (int i = 1; i <= 8; i++) push_a(8'(i));
      exp_a.push_back(8'd1);
      cyc_a(1'b1, 8'd99, 1'b1, 1'b0);
      stat_a("full_wr_rd", 8, 0, 1, 0, 1, 0, 0);
      for (int i = 2; i <= 8; i++) pop_a(8'(i));
      pop_a(8'd99);
      idle_a();
      check("full_wr_rd_drain", a_if.fifo_counter, 0);

      // Simultaneous write and read while empty
      cyc_a(1'b1, 8'd33, 1'b1, 1'b0);
      check("empty_wr_rd_udf", a_if.underflow, 1);
      check("empty_wr_rd_count", a_if.fifo_counter, 1);
      pop_a(8'd33);
      idle_a();
      check("empty_wr_rd_drain", a_if.fifo_counter, 0);

      // Underflow stickiness and clear priority
      cyc_a(1'b0, '0, 1'b0, 1'b1);
      check("udf_clr1", a_if.underflow, 0);
      cyc_a(1'b0, '0, 1'b1, 1'b0);
      check("udf_set", a_if.underflow, 1);
      check("udf_bufout_hold", a_if.buf_out, 33);
      cyc_a(1'b0, '0, 1'b0, 1'b1);
      check("udf_clr2", a_if.underflow, 0);
      cyc_a(1'b0, '0, 1'b1, 1'b1);
      check("udf_set_beats_clr", a_if.underflow, 1);
      check("udf_count", a_if.fifo_counter, 0);

      // Fall-through instance
      cyc_f(1'b1, 8'd44, 1'b0);
      check("fwft_show44", f_if.buf_out, 44);
      check("fwft_nonempty", f_if.buf_empty, 0);
      cyc_f(1'b1, 8'd55, 1'b0);
      check("fwft_hold44", f_if.buf_out, 44);
      check("fwft_count2", f_if.fifo_counter, 2);
      pop_f(8'd44);
      check("fwft_show55", f_if.buf_out, 55);
      check("fwft_count1", f_if.fifo_counter, 1);
      pop_f(8'd55);
      check("fwft_empty", f_if.buf_empty, 1);
      check("fwft_count0", f_if.fifo_counter, 0);

      repeat (2) @(negedge clk);
      check("sb_a_drained", exp_a.size(), 0);
      check("sb_f_drained", exp_f.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
